// File: rtl/spi_status_flags_n_pkg.sv
// +--------------------------------------------------------------------+
// | spi_sr_pkg: shared constants and types for the SPI status flags    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package spi_sr_pkg;

    localparam int SPI_MAX_FLAGS = 16;

    localparam int SPTEF_IDX = 0;
    localparam int SPIF_IDX  = 1;
    localparam int MODF_IDX  = 2;

    localparam logic [SPI_MAX_FLAGS-1:0] SPI_DEF_EDGE_MASK    = 16'h0000;
    localparam logic [SPI_MAX_FLAGS-1:0] SPI_DEF_SEQ_CLR_MASK = 16'h0003;

    typedef enum logic [1:0] {
        UPD_HOLD = 2'd0,
        UPD_SET  = 2'd1,
        UPD_CLR  = 2'd2
    } flag_upd_e;

    // A set event always beats a clear request arriving in the same cycle.
    function automatic flag_upd_e flag_update(input logic set_evt, input logic clr);
        if (set_evt)
            return UPD_SET;
        else if (clr)
            return UPD_CLR;
        else
            return UPD_HOLD;
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_status_flags_n_if.sv
// +--------------------------------------------------------------------+
// | spi_status_flags_n_if: SPI core / register side of the flag block  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

interface spi_status_flags_n_if #(
    parameter int NUM_FLAGS = 4
);
    logic [NUM_FLAGS-1:0] flag_in;
    logic [NUM_FLAGS-1:0] int_en;
    logic                 sr_read;
    logic                 dr_access;
    logic                 w1c_we;
    logic [NUM_FLAGS-1:0] w1c_data;
    logic [NUM_FLAGS-1:0] ovr_clr;
    logic [NUM_FLAGS-1:0] status;
    logic [NUM_FLAGS-1:0] ovr;
    logic                 irq;

    modport master (
        output flag_in, int_en, sr_read, dr_access, w1c_we, w1c_data, ovr_clr,
        input  status, ovr, irq
    );

    modport slave (
        input  flag_in, int_en, sr_read, dr_access, w1c_we, w1c_data, ovr_clr,
        output status, ovr, irq
    );
endinterface

`default_nettype wire

// File: rtl/spi_status_flags_n_flag_cell.sv
// +--------------------------------------------------------------------+
// | spi_flag_cell: one sticky flag with sequence/W1C clear and overrun |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module spi_flag_cell
    import spi_sr_pkg::*;
#(
    parameter bit EDGE    = 1'b0,
    parameter bit SEQ_CLR = 1'b0
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic flag_in,
    input  wire logic sr_read,
    input  wire logic dr_access,
    input  wire logic w1c,
    input  wire logic ovr_clr,
    output logic      status,
    output logic      ovr
);

    logic      r_flag_d;
    logic      r_status;
    logic      r_armed;
    logic      r_ovr;
    logic      w_set_evt;
    logic      w_clr;
    flag_upd_e w_upd;

    always_comb begin
        w_set_evt = EDGE ? (flag_in & ~r_flag_d) : flag_in;
        // r_armed is the value from before this cycle, so a same-cycle
        // sr_read cannot arm-and-clear a flag in one step.
        w_clr     = w1c | (SEQ_CLR & dr_access & r_armed);
        w_upd     = flag_update(w_set_evt, w_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flag_d <= 1'b0;
            r_status <= 1'b0;
            r_armed  <= 1'b0;
            r_ovr    <= 1'b0;
        end else begin
            r_flag_d <= flag_in;

            case (w_upd)
                UPD_SET:  r_status <= 1'b1;
                UPD_CLR:  r_status <= 1'b0;
                default:  r_status <= r_status;
            endcase

            if (sr_read)
                r_armed <= r_status;
            else if (dr_access | w1c | (w_set_evt & w_clr))
                r_armed <= 1'b0;

            if (w_set_evt & r_status & ~w_clr)
                r_ovr <= 1'b1;
            else if (ovr_clr)
                r_ovr <= 1'b0;
        end
    end

    assign status = r_status;
    assign ovr    = r_ovr;

endmodule

`default_nettype wire

// File: rtl/spi_status_flags_n.sv
// +--------------------------------------------------------------------+
// | spi_status_flags_n: SPI sticky status flags with masked interrupt  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module spi_status_flags_n
    import spi_sr_pkg::*;
#(
    parameter int                       NUM_FLAGS    = 4,
    parameter logic [SPI_MAX_FLAGS-1:0] EDGE_MASK    = SPI_DEF_EDGE_MASK,
    parameter logic [SPI_MAX_FLAGS-1:0] SEQ_CLR_MASK = SPI_DEF_SEQ_CLR_MASK,
    parameter bit                       IRQ_PULSE    = 1'b0
) (
    input  wire logic             clk,
    input  wire logic             rst,
    spi_status_flags_n_if.slave   bus
);

    logic [NUM_FLAGS-1:0] w_status;
    logic [NUM_FLAGS-1:0] w_ovr;
    logic [NUM_FLAGS-1:0] w_pending;
    logic                 r_irq;

    generate
        for (genvar gi = 0; gi < NUM_FLAGS; gi++) begin : g_flag
            spi_flag_cell #(
                .EDGE    (EDGE_MASK[gi]),
                .SEQ_CLR (SEQ_CLR_MASK[gi])
            ) u_cell (
                .clk       (clk),
                .rst       (rst),
                .flag_in   (bus.flag_in[gi]),
                .sr_read   (bus.sr_read),
                .dr_access (bus.dr_access),
                .w1c       (bus.w1c_we & bus.w1c_data[gi]),
                .ovr_clr   (bus.ovr_clr[gi]),
                .status    (w_status[gi]),
                .ovr       (w_ovr[gi])
            );
        end
    endgenerate

    assign w_pending = w_status & bus.int_en;

    generate
        if (IRQ_PULSE) begin : g_irq_pulse
            logic [NUM_FLAGS-1:0] r_pending_d;

            // Edge-detecting pending (not status) makes a late int_en also pulse.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_pending_d <= '0;
                    r_irq       <= 1'b0;
                end else begin
                    r_pending_d <= w_pending;
                    r_irq       <= |(w_pending & ~r_pending_d);
                end
            end
        end else begin : g_irq_level
            always_ff @(posedge clk) begin
                if (rst)
                    r_irq <= 1'b0;
                else
                    r_irq <= |w_pending;
            end
        end
    endgenerate

    assign bus.status = w_status;
    assign bus.ovr    = w_ovr;
    assign bus.irq    = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_spi_status_flags_n.sv
// +--------------------------------------------------------------------+
// | tb_spi_status_flags_n: directed checks for level and pulse builds  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_spi_status_flags_n;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    spi_status_flags_n_if #(.NUM_FLAGS(4)) bus_a ();
    spi_status_flags_n_if #(.NUM_FLAGS(4)) bus_p ();

    // Level irq, bit3 edge-captured, bits 0/1 sequence-clearable.
    spi_status_flags_n #(
        .NUM_FLAGS    (4),
        .EDGE_MASK    (16'h0008),
        .SEQ_CLR_MASK (16'h0003),
        .IRQ_PULSE    (1'b0)
    ) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    spi_status_flags_n #(
        .NUM_FLAGS    (4),
        .EDGE_MASK    (16'h0000),
        .SEQ_CLR_MASK (16'h0003),
        .IRQ_PULSE    (1'b1)
    ) u_dut_p (
        .clk (clk),
        .rst (rst),
        .bus (bus_p.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus_a.flag_in = '0; bus_a.int_en = '0; bus_a.sr_read = 1'b0; bus_a.dr_access = 1'b0;
        bus_a.w1c_we = 1'b0; bus_a.w1c_data = '0; bus_a.ovr_clr = '0;
        bus_p.flag_in = '0; bus_p.int_en = '0; bus_p.sr_read = 1'b0; bus_p.dr_access = 1'b0;
        bus_p.w1c_we = 1'b0; bus_p.w1c_data = '0; bus_p.ovr_clr = '0;
        step(); step();
        rst = 1'b0;
        chk("reset_status", {12'b0, bus_a.status}, 16'h0000);
        chk("reset_ovr",    {12'b0, bus_a.ovr},    16'h0000);
        chk("reset_irq",    {15'b0, bus_a.irq},    16'h0000);

        // 1: level flag0, irq one cycle after status
        bus_a.int_en = 4'b0001;
        bus_a.flag_in = 4'b0001; step(); bus_a.flag_in = 4'b0000;
        chk("t1_status_set", {12'b0, bus_a.status}, 16'h0001);
        chk("t1_irq_not_yet", {15'b0, bus_a.irq}, 16'h0000);
        step();
        chk("t1_irq_up", {15'b0, bus_a.irq}, 16'h0001);
        chk("t1_sticky", {12'b0, bus_a.status}, 16'h0001);
        bus_a.w1c_we = 1'b1; bus_a.w1c_data = 4'b0001; step();
        bus_a.w1c_we = 1'b0; bus_a.w1c_data = 4'b0000;
        chk("t1_w1c_clear", {12'b0, bus_a.status}, 16'h0000);
        step();
        chk("t1_irq_drop", {15'b0, bus_a.irq}, 16'h0000);

        // 2: sequence clear of flag1
        bus_a.flag_in = 4'b0010; step(); bus_a.flag_in = 4'b0000;
        chk("t2_set", {12'b0, bus_a.status}, 16'h0002);
        bus_a.dr_access = 1'b1; step(); bus_a.dr_access = 1'b0;
        chk("t2_dr_without_read", {12'b0, bus_a.status}, 16'h0002);
        bus_a.sr_read = 1'b1; step(); bus_a.sr_read = 1'b0;
        step(); step(); step();
        bus_a.dr_access = 1'b1; step(); bus_a.dr_access = 1'b0;
        chk("t2_seq_clear", {12'b0, bus_a.status}, 16'h0000);

        // 3: flag set after the read survives; read+access together only re-arms
        bus_a.flag_in = 4'b0010; step(); bus_a.flag_in = 4'b0000;
        bus_a.sr_read = 1'b1; bus_a.dr_access = 1'b1; step();
        bus_a.sr_read = 1'b0; bus_a.dr_access = 1'b0;
        chk("t3_same_cycle_no_clear", {12'b0, bus_a.status}, 16'h0002);
        bus_a.flag_in = 4'b0001; step(); bus_a.flag_in = 4'b0000;
        chk("t3_both_set", {12'b0, bus_a.status}, 16'h0003);
        bus_a.dr_access = 1'b1; step(); bus_a.dr_access = 1'b0;
        chk("t3_unarmed_survives", {12'b0, bus_a.status}, 16'h0001);
        bus_a.w1c_we = 1'b1; bus_a.w1c_data = 4'b1111; step();
        bus_a.w1c_we = 1'b0; bus_a.w1c_data = 4'b0000;
        chk("t3_clear_all", {12'b0, bus_a.status}, 16'h0000);

        // 4: set/clear collision on flag2 and overrun
        bus_a.flag_in = 4'b0100; step();
        chk("t4_set", {12'b0, bus_a.status}, 16'h0004);
        bus_a.w1c_we = 1'b1; bus_a.w1c_data = 4'b0100; step();
        bus_a.w1c_we = 1'b0; bus_a.w1c_data = 4'b0000;
        chk("t4_set_wins", {12'b0, bus_a.status}, 16'h0004);
        chk("t4_no_ovr_on_clr", {12'b0, bus_a.ovr}, 16'h0000);
        step(); bus_a.flag_in = 4'b0000;
        chk("t4_ovr_set", {12'b0, bus_a.ovr}, 16'h0004);
        bus_a.ovr_clr = 4'b0100; step(); bus_a.ovr_clr = 4'b0000;
        chk("t4_ovr_clr", {12'b0, bus_a.ovr}, 16'h0000);
        chk("t4_status_kept", {12'b0, bus_a.status}, 16'h0004);
        bus_a.w1c_we = 1'b1; bus_a.w1c_data = 4'b0100; step();
        bus_a.w1c_we = 1'b0; bus_a.w1c_data = 4'b0000;

        // 5: edge-captured flag3
        bus_a.flag_in = 4'b1000;
        step(); step(); step(); step(); step();
        chk("t5_one_set", {12'b0, bus_a.status}, 16'h0008);
        chk("t5_no_ovr", {12'b0, bus_a.ovr}, 16'h0000);
        bus_a.w1c_we = 1'b1; bus_a.w1c_data = 4'b1000; step();
        bus_a.w1c_we = 1'b0; bus_a.w1c_data = 4'b0000;
        step();
        chk("t5_held_high_stays_clear", {12'b0, bus_a.status}, 16'h0000);
        bus_a.flag_in = 4'b0000; step();
        bus_a.flag_in = 4'b1000; step();
        chk("t5_rise_again", {12'b0, bus_a.status}, 16'h0008);
        bus_a.flag_in = 4'b0000;

        // 6: pulse irq build
        bus_p.int_en = 4'b1111;
        bus_p.flag_in = 4'b0001; step(); bus_p.flag_in = 4'b0000;
        chk("t6_irq_wait", {15'b0, bus_p.irq}, 16'h0000);
        step();
        chk("t6_pulse1", {15'b0, bus_p.irq}, 16'h0001);
        step();
        chk("t6_pulse1_end", {15'b0, bus_p.irq}, 16'h0000);
        step();
        bus_p.flag_in = 4'b0100; step(); bus_p.flag_in = 4'b0000;
        chk("t6_status2", {12'b0, bus_p.status}, 16'h0005);
        step();
        chk("t6_pulse2", {15'b0, bus_p.irq}, 16'h0001);
        step();
        chk("t6_pulse2_end", {15'b0, bus_p.irq}, 16'h0000);
        bus_p.flag_in = 4'b0010; step(); bus_p.flag_in = 4'b0000;
        rst = 1'b1; step();
        chk("t6_rst_status", {12'b0, bus_p.status}, 16'h0000);
        chk("t6_rst_ovr", {12'b0, bus_p.ovr}, 16'h0000);
        chk("t6_rst_irq", {15'b0, bus_p.irq}, 16'h0000);
        rst = 1'b0; step();
        chk("t6_after_rst_irq", {15'b0, bus_p.irq}, 16'h0000);

        // late int_en in pulse mode
        bus_p.int_en = 4'b0000;
        bus_p.flag_in = 4'b0001; step(); bus_p.flag_in = 4'b0000;
        step();
        chk("t6_masked", {15'b0, bus_p.irq}, 16'h0000);
        bus_p.int_en = 4'b1111; step();
        chk("t6_late_en_pulse", {15'b0, bus_p.irq}, 16'h0001);
        step();
        chk("t6_late_en_end", {15'b0, bus_p.irq}, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
